id_pipe: RTL and testbench

ID_PIPE -- requirements
Module: id_pipe

---
 rtl/id_pipe.sv | 279 +++++++++++++++++++++++++++
 tb/tb_id_pipe.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_pipe.sv
// id_pipe: MIPS-style instruction decode stage with a ready/valid handshake, EX/MEM operand
// forwarding, load-use stall and stall counter. Optional macro: ID_FORWARD_EN (forwarding on).
module id_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_i,
  input  logic [31:0]       inst_i,
  input  logic              inst_valid_i,
  output logic              inst_ready_o,
  input  logic              flush_i,
  output logic              reg1_read_o,
  output logic              reg2_read_o,
  output logic [REG_AW-1:0] reg1_addr_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_is_load_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              ex_ready_i,
  output logic              id_valid_o,
  output logic [31:0]       pc_o,
  output logic [7:0]        aluop_o,
  output logic [2:0]        alusel_o,
  output logic [DATA_W-1:0] reg1_o,
  output logic [DATA_W-1:0] reg2_o,
  output logic [REG_AW-1:0] wd_o,
  output logic              wreg_o,
  output logic              inst_err_o,
  output logic [15:0]       stall_cnt_o
);

  typedef enum logic [2:0] {
    SEL_NOP   = 3'b000,
    SEL_LOGIC = 3'b001,
    SEL_SHIFT = 3'b010,
    SEL_ARITH = 3'b011,
    SEL_LOAD  = 3'b111
  } alusel_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

  localparam logic [7:0] ALU_AND  = 8'h24;
  localparam logic [7:0] ALU_OR   = 8'h25;
  localparam logic [7:0] ALU_XOR  = 8'h26;
  localparam logic [7:0] ALU_ADDU = 8'h21;
  localparam logic [7:0] ALU_LW   = 8'hE3;

  // Instruction fields
  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [4:0]        w_shamt;
  logic [15:0]       w_imm;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;

  assign w_opcode = inst_i[31:26];
  assign w_funct  = inst_i[5:0];
  assign w_shamt  = inst_i[10:6];
  assign w_imm    = inst_i[15:0];
  assign w_rs     = REG_AW'(inst_i[25:21]);
  assign w_rt     = REG_AW'(inst_i[20:16]);
  assign w_rd     = REG_AW'(inst_i[15:11]);

  // Decoded control; w_imm1/w_imm2 supply an operand whenever its register port is unused.
  logic [7:0]        w_aluop;
  alusel_e           w_alusel;
  logic              w_rd1_en;
  logic              w_rd2_en;
  logic [REG_AW-1:0] w_a1;
  logic [REG_AW-1:0] w_a2;
  logic [DATA_W-1:0] w_imm1;
  logic [DATA_W-1:0] w_imm2;
  logic [REG_AW-1:0] w_wd;
  logic              w_wreg;
  logic              w_err;

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no decode path can infer a latch.
    w_aluop  = '0;
    w_alusel = SEL_NOP;
    w_rd1_en = 1'b0;
    w_rd2_en = 1'b0;
    w_a1     = w_rs;
    w_a2     = w_rt;
    w_imm1   = '0;
    w_imm2   = '0;
    w_wd     = '0;
    w_wreg   = 1'b0;
    w_err    = 1'b0;
    case (w_opcode)
      OP_SPECIAL: begin
        w_rd1_en = 1'b1;
        w_rd2_en = 1'b1;
        w_wd     = w_rd;
        w_wreg   = 1'b1;
        w_aluop  = {2'b00, w_funct};
        case (w_funct)
          FN_OR, FN_AND, FN_XOR, FN_NOR: w_alusel = SEL_LOGIC;
          FN_ADDU, FN_SUBU:              w_alusel = SEL_ARITH;
          FN_SLL, FN_SRL: begin
            // Shifts take the shift amount as operand 1 and shift rt.
            w_alusel = SEL_SHIFT;
            w_rd1_en = 1'b0;
            w_imm1   = DATA_W'(w_shamt);
          end
          default: begin
            w_rd1_en = 1'b0;
            w_rd2_en = 1'b0;
            w_wd     = '0;
            w_wreg   = 1'b0;
            w_aluop  = '0;
            w_err    = 1'b1;
          end
        endcase
      end
      OP_ORI, OP_ANDI, OP_XORI: begin
        w_rd1_en = 1'b1;
        w_imm2   = DATA_W'(w_imm);
        w_wd     = w_rt;
        w_wreg   = 1'b1;
        w_alusel = SEL_LOGIC;
        w_aluop  = (w_opcode == OP_ORI)  ? ALU_OR :
                   (w_opcode == OP_ANDI) ? ALU_AND : ALU_XOR;
      end
      OP_LUI: begin
        w_imm2   = DATA_W'($signed({w_imm, 16'h0000}));
        w_wd     = w_rt;
        w_wreg   = 1'b1;
        w_alusel = SEL_LOGIC;
        w_aluop  = ALU_OR;
      end
      OP_ADDIU, OP_LW: begin
        w_rd1_en = 1'b1;
        w_imm2   = DATA_W'($signed(w_imm));
        w_wd     = w_rt;
        w_wreg   = 1'b1;
        w_alusel = (w_opcode == OP_LW) ? SEL_LOAD : SEL_ARITH;
        w_aluop  = (w_opcode == OP_LW) ? ALU_LW : ALU_ADDU;
      end
      default: w_err = 1'b1;
    endcase
  end

  // Read enables only reflect a real instruction, so an idle input never raises a hazard.
  logic w_rd1;
  logic w_rd2;
  assign w_rd1       = rst && inst_valid_i && w_rd1_en;
  assign w_rd2       = rst && inst_valid_i && w_rd2_en;
  assign reg1_read_o = w_rd1;
  assign reg2_read_o = w_rd2;
  assign reg1_addr_o = w_a1;
  assign reg2_addr_o = w_a2;

  logic w_ex_hit1;
  logic w_ex_hit2;
  logic w_mem_hit1;
  logic w_mem_hit2;
  assign w_ex_hit1  = w_rd1 && ex_wreg_i  && (ex_wd_i  == w_a1) && (w_a1 != '0);
  assign w_ex_hit2  = w_rd2 && ex_wreg_i  && (ex_wd_i  == w_a2) && (w_a2 != '0);
  assign w_mem_hit1 = w_rd1 && mem_wreg_i && (mem_wd_i == w_a1) && (w_a1 != '0);
  assign w_mem_hit2 = w_rd2 && mem_wreg_i && (mem_wd_i == w_a2) && (w_a2 != '0);

  logic              w_hazard;
  logic [DATA_W-1:0] w_src1;
  logic [DATA_W-1:0] w_src2;

`ifdef ID_FORWARD_EN
  // The youngest writer wins; only a load still in EX has no data to forward yet.
  assign w_hazard = ex_is_load_i && (w_ex_hit1 || w_ex_hit2);
  assign w_src1   = w_ex_hit1 ? ex_wdata_i : (w_mem_hit1 ? mem_wdata_i : reg1_data_i);
  assign w_src2   = w_ex_hit2 ? ex_wdata_i : (w_mem_hit2 ? mem_wdata_i : reg2_data_i);
`else
  // Without forwarding, any in-flight writer of a source must retire before issue.
  assign w_hazard = w_ex_hit1 || w_ex_hit2 || w_mem_hit1 || w_mem_hit2;
  assign w_src1   = reg1_data_i;
  assign w_src2   = reg2_data_i;
  logic w_unused_fwd;
  assign w_unused_fwd = ^{ex_wdata_i, mem_wdata_i, ex_is_load_i};
`endif

  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;
  assign w_op1 = !w_rd1_en ? w_imm1 : ((w_a1 == '0) ? '0 : w_src1);
  assign w_op2 = !w_rd2_en ? w_imm2 : ((w_a2 == '0) ? '0 : w_src2);

  // Handshake
  logic r_id_valid;
  logic w_can_load;
  assign w_can_load   = !r_id_valid || ex_ready_i;
  assign inst_ready_o = rst && w_can_load && !w_hazard && !flush_i;

  logic [31:0]       r_pc;
  logic [7:0]        r_aluop;
  alusel_e           r_alusel;
  logic [DATA_W-1:0] r_reg1;
  logic [DATA_W-1:0] r_reg2;
  logic [REG_AW-1:0] r_wd;
  logic              r_wreg;
  logic              r_inst_err;
  logic [15:0]       r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id_valid <= 1'b0;
      r_pc       <= '0;
      r_aluop    <= '0;
      r_alusel   <= SEL_NOP;
      r_reg1     <= '0;
      r_reg2     <= '0;
      r_wd       <= '0;
      r_wreg     <= 1'b0;
      r_inst_err <= 1'b0;
    end else if (flush_i) begin
      r_id_valid <= 1'b0;
      r_wreg     <= 1'b0;
    end else if (w_can_load) begin
      if (inst_valid_i && !w_hazard) begin
        // NOTE: non-blocking updates make every register sample pre-edge values together.
        r_id_valid <= 1'b1;
        r_pc       <= pc_i;
        r_aluop    <= w_aluop;
        r_alusel   <= w_alusel;
        r_reg1     <= w_op1;
        r_reg2     <= w_op2;
        r_wd       <= w_wd;
        r_wreg     <= w_wreg;
        r_inst_err <= w_err;
      end else begin
        r_id_valid <= 1'b0;
        r_wreg     <= 1'b0;
        r_inst_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (inst_valid_i && w_hazard && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign id_valid_o  = r_id_valid;
  assign pc_o        = r_pc;
  assign aluop_o     = r_aluop;
  assign alusel_o    = r_alusel;
  assign reg1_o      = r_reg1;
  assign reg2_o      = r_reg2;
  assign wd_o        = r_wd;
  assign wreg_o      = r_wreg;
  assign inst_err_o  = r_inst_err;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_id_pipe.sv
// tb_id_pipe: directed-vector bench for id_pipe (DATA_W=64), one task per scenario.
module tb_id_pipe;
  localparam int DATA_W = 64;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       pc_i;
  logic [31:0]       inst_i;
  logic              inst_valid_i;
  logic              inst_ready_o;
  logic              flush_i;
  logic              reg1_read_o;
  logic              reg2_read_o;
  logic [REG_AW-1:0] reg1_addr_o;
  logic [REG_AW-1:0] reg2_addr_o;
  logic [DATA_W-1:0] reg1_data_i;
  logic [DATA_W-1:0] reg2_data_i;
  logic              ex_wreg_i;
  logic [REG_AW-1:0] ex_wd_i;
  logic [DATA_W-1:0] ex_wdata_i;
  logic              ex_is_load_i;
  logic              mem_wreg_i;
  logic [REG_AW-1:0] mem_wd_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic              ex_ready_i;
  logic              id_valid_o;
  logic [31:0]       pc_o;
  logic [7:0]        aluop_o;
  logic [2:0]        alusel_o;
  logic [DATA_W-1:0] reg1_o;
  logic [DATA_W-1:0] reg2_o;
  logic [REG_AW-1:0] wd_o;
  logic              wreg_o;
  logic              inst_err_o;
  logic [15:0]       stall_cnt_o;

  id_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .inst_ready_o(inst_ready_o), .flush_i(flush_i), .reg1_read_o(reg1_read_o),
    .reg2_read_o(reg2_read_o), .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i), .ex_wreg_i(ex_wreg_i),
    .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .ex_ready_i(ex_ready_i), .id_valid_o(id_valid_o), .pc_o(pc_o), .aluop_o(aluop_o),
    .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .inst_err_o(inst_err_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  // {id_valid, wreg, inst_err, alusel[2:0], aluop[7:0], wd[4:0]}
  logic [18:0] ctl;
  assign ctl = {id_valid_o, wreg_o, inst_err_o, alusel_o, aluop_o, wd_o};

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0]       inst;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] r1;
    logic [DATA_W-1:0] r2;
    logic [18:0]       ctl;
  } vec_t;

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_valid_i = 1'b0; flush_i = 1'b0; ex_ready_i = 1'b1;
    ex_wreg_i = 1'b0; ex_wd_i = '0; ex_wdata_i = '0; ex_is_load_i = 1'b0;
    mem_wreg_i = 1'b0; mem_wd_i = '0; mem_wdata_i = '0;
    pc_i = '0; inst_i = '0; reg1_data_i = '0; reg2_data_i = '0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] inst,
                       input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2);
    pc_i = pc; inst_i = inst; reg1_data_i = d1; reg2_data_i = d2; inst_valid_i = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    issue(32'h10, itype(6'h0D, 5'd1, 5'd2, 16'h1), 64'h5, 64'h0);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({inst_ready_o, reg1_read_o, reg2_read_o} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_handshake: got %b expected 000", {inst_ready_o, reg1_read_o, reg2_read_o});
    end
    step(); step();
    n_checks++;
    if ({ctl, reg1_o, reg2_o, pc_o, stall_cnt_o} !== '0) begin
      n_errors++;
      $display("FAIL reset_regs: ctl=%h reg1=%h reg2=%h pc=%h stall=%h expected all zero",
               ctl, reg1_o, reg2_o, pc_o, stall_cnt_o);
    end
    rst = 1'b1;
    inst_valid_i = 1'b0;
    step();
  endtask

  task automatic test_ori();
    issue(32'h40, itype(6'h0D, 5'd1, 5'd2, 16'h8000), 64'hF0, 64'h0);
    #1;
    n_checks++;
    if ({inst_ready_o, reg1_read_o, reg2_read_o, reg1_addr_o} !== {3'b110, 5'd1}) begin
      n_errors++;
      $display("FAIL ori_read: got %b expected %b",
               {inst_ready_o, reg1_read_o, reg2_read_o, reg1_addr_o}, {3'b110, 5'd1});
    end
    step();
    n_checks++;
    if (ctl !== {3'b110, 3'b001, 8'h25, 5'd2}) begin
      n_errors++;
      $display("FAIL ori_ctl: got %h expected %h", ctl, {3'b110, 3'b001, 8'h25, 5'd2});
    end
    n_checks++;
    if ({reg1_o, reg2_o, pc_o} !== {64'hF0, 64'h8000, 32'h40}) begin
      n_errors++;
      $display("FAIL ori_data: reg1=%h reg2=%h pc=%h expected f0 8000 40", reg1_o, reg2_o, pc_o);
    end
    inst_valid_i = 1'b0;
    step();
    n_checks++;
    if ({id_valid_o, wreg_o} !== 2'b00) begin
      n_errors++;
      $display("FAIL idle_bubble: got %b expected 00", {id_valid_o, wreg_o});
    end
  endtask

  task automatic test_immediates();
    issue(32'h44, itype(6'h09, 5'd5, 5'd6, 16'hFFFF), 64'h10, 64'h0);
    step();
    n_checks++;
    if ({ctl, reg1_o, reg2_o} !== {3'b110, 3'b011, 8'h21, 5'd6, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      n_errors++;
      $display("FAIL addiu: ctl=%h reg1=%h reg2=%h expected ctl=%h reg1=10 reg2=ffffffffffffffff",
               ctl, reg1_o, reg2_o, {3'b110, 3'b011, 8'h21, 5'd6});
    end
    issue(32'h48, itype(6'h0F, 5'd3, 5'd7, 16'h8001), 64'hDEAD, 64'h0);
    #1;
    n_checks++;
    if (reg1_read_o !== 1'b0) begin
      n_errors++;
      $display("FAIL lui_read: got %b expected 0", reg1_read_o);
    end
    step();
    n_checks++;
    if ({ctl, reg1_o, reg2_o} !== {3'b110, 3'b001, 8'h25, 5'd7, 64'h0, 64'hFFFF_FFFF_8001_0000}) begin
      n_errors++;
      $display("FAIL lui: ctl=%h reg1=%h reg2=%h expected ctl=%h reg1=0 reg2=ffffffff80010000",
               ctl, reg1_o, reg2_o, {3'b110, 3'b001, 8'h25, 5'd7});
    end
    inst_valid_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    vec_t v[7];
    v[0] = '{rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h23), 64'h11, 64'h22, 64'h11, 64'h22,
             {3'b110, 3'b011, 8'h23, 5'd3}};
    v[1] = '{rtype(5'd7, 5'd2, 5'd4, 5'd5, 6'h00), 64'h77, 64'h22, 64'h5, 64'h22,
             {3'b110, 3'b010, 8'h00, 5'd4}};
    v[2] = '{rtype(5'd1, 5'd2, 5'd10, 5'd0, 6'h27), 64'h11, 64'h22, 64'h11, 64'h22,
             {3'b110, 3'b001, 8'h27, 5'd10}};
    v[3] = '{rtype(5'd0, 5'd2, 5'd1, 5'd0, 6'h25), 64'hAAAA, 64'h22, 64'h0, 64'h22,
             {3'b110, 3'b001, 8'h25, 5'd1}};
    v[4] = '{itype(6'h23, 5'd1, 5'd12, 16'h8000), 64'h11, 64'h0, 64'h11, 64'hFFFF_FFFF_FFFF_8000,
             {3'b110, 3'b111, 8'hE3, 5'd12}};
    v[5] = '{rtype(5'd0, 5'd3, 5'd5, 5'd31, 6'h02), 64'h0, 64'h33, 64'd31, 64'h33,
             {3'b110, 3'b010, 8'h02, 5'd5}};
    v[6] = '{itype(6'h0C, 5'd2, 5'd13, 16'hF00F), 64'h22, 64'h0, 64'h22, 64'hF00F,
             {3'b110, 3'b001, 8'h24, 5'd13}};
    for (int i = 0; i < 7; i++) begin
      issue(32'h100 + 32'(i * 4), v[i].inst, v[i].d1, v[i].d2);
      step();
      n_checks++;
      if ({ctl, reg1_o, reg2_o, pc_o} !== {v[i].ctl, v[i].r1, v[i].r2, 32'h100 + 32'(i * 4)}) begin
        n_errors++;
        $display("FAIL vec%0d: ctl=%h reg1=%h reg2=%h pc=%h expected ctl=%h reg1=%h reg2=%h",
                 i, ctl, reg1_o, reg2_o, pc_o, v[i].ctl, v[i].r1, v[i].r2);
      end
    end
    inst_valid_i = 1'b0;
  endtask

  task automatic test_load_use();
    idle();
    step();
    n_checks++;
    if (stall_cnt_o !== 16'd0) begin
      n_errors++;
      $display("FAIL stall_start: got %0d expected 0", stall_cnt_o);
    end
    ex_wreg_i = 1'b1; ex_wd_i = 5'd4; ex_wdata_i = 64'h4444; ex_is_load_i = 1'b1;
    issue(32'h200, rtype(5'd4, 5'd1, 5'd8, 5'd0, 6'h21), 64'h40, 64'h1);
    #1;
    n_checks++;
    if (inst_ready_o !== 1'b0) begin
      n_errors++;
      $display("FAIL load_use_ready: got %b expected 0", inst_ready_o);
    end
    step();
    n_checks++;
    if ({id_valid_o, wreg_o, stall_cnt_o} !== {2'b00, 16'd1}) begin
      n_errors++;
      $display("FAIL load_use_bubble: valid=%b wreg=%b stall=%0d expected 0 0 1",
               id_valid_o, wreg_o, stall_cnt_o);
    end
    ex_wreg_i = 1'b0; ex_is_load_i = 1'b0; reg1_data_i = 64'h4444;
    #1;
    n_checks++;
    if (inst_ready_o !== 1'b1) begin
      n_errors++;
      $display("FAIL load_retired_ready: got %b expected 1", inst_ready_o);
    end
    step();
    n_checks++;
    if ({ctl, reg1_o, reg2_o, stall_cnt_o} !== {3'b110, 3'b011, 8'h21, 5'd8, 64'h4444, 64'h1, 16'd1}) begin
      n_errors++;
      $display("FAIL load_use_issue: ctl=%h reg1=%h reg2=%h stall=%0d expected ctl=%h 4444 1 1",
               ctl, reg1_o, reg2_o, stall_cnt_o, {3'b110, 3'b011, 8'h21, 5'd8});
    end
    inst_valid_i = 1'b0;
  endtask

  task automatic test_forward();
    logic [15:0] s0;
    idle();
    step();
    s0 = stall_cnt_o;
    ex_wreg_i = 1'b1; ex_wd_i = 5'd3; ex_wdata_i = 64'h1234;
    mem_wreg_i = 1'b1; mem_wd_i = 5'd3; mem_wdata_i = 64'h5678;
    issue(32'h300, rtype(5'd3, 5'd0, 5'd5, 5'd0, 6'h25), 64'h9999, 64'h0);
    #1;
`ifdef ID_FORWARD_EN
    n_checks++;
    if (inst_ready_o !== 1'b1) begin
      n_errors++;
      $display("FAIL fwd_ready: got %b expected 1", inst_ready_o);
    end
    step();
    n_checks++;
    if ({id_valid_o, reg1_o, reg2_o} !== {1'b1, 64'h1234, 64'h0}) begin
      n_errors++;
      $display("FAIL fwd_ex: valid=%b reg1=%h reg2=%h expected 1 1234 0", id_valid_o, reg1_o, reg2_o);
    end
    ex_wreg_i = 1'b0;
    step();
    n_checks++;
    if (reg1_o !== 64'h5678) begin
      n_errors++;
      $display("FAIL fwd_mem: got %h expected 5678", reg1_o);
    end
`else
    n_checks++;
    if (inst_ready_o !== 1'b0) begin
      n_errors++;
      $display("FAIL nofwd_ready: got %b expected 0", inst_ready_o);
    end
    step(); step();
    n_checks++;
    if ({id_valid_o, stall_cnt_o} !== {1'b0, s0 + 16'd2}) begin
      n_errors++;
      $display("FAIL nofwd_stall: valid=%b stall=%0d expected 0 %0d", id_valid_o, stall_cnt_o, s0 + 16'd2);
    end
    ex_wreg_i = 1'b0; mem_wreg_i = 1'b0;
    #1;
    n_checks++;
    if (inst_ready_o !== 1'b1) begin
      n_errors++;
      $display("FAIL nofwd_retired_ready: got %b expected 1", inst_ready_o);
    end
    step();
    n_checks++;
    if ({id_valid_o, reg1_o} !== {1'b1, 64'h9999}) begin
      n_errors++;
      $display("FAIL nofwd_issue: valid=%b reg1=%h expected 1 9999", id_valid_o, reg1_o);
    end
`endif
    idle();
  endtask

  task automatic test_backpressure();
    issue(32'h400, itype(6'h0E, 5'd1, 5'd9, 16'h00FF), 64'h0F0F, 64'h0);
    step();
    ex_ready_i = 1'b0;
    issue(32'h404, itype(6'h0C, 5'd2, 5'd10, 16'h00F0), 64'h5555, 64'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (inst_ready_o !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_ready%0d: got %b expected 0", i, inst_ready_o);
      end
      step();
      n_checks++;
      if ({ctl, reg1_o, reg2_o, pc_o} !== {3'b110, 3'b001, 8'h26, 5'd9, 64'h0F0F, 64'hFF, 32'h400}) begin
        n_errors++;
        $display("FAIL hold%0d: ctl=%h reg1=%h reg2=%h pc=%h expected xori held", i, ctl, reg1_o, reg2_o, pc_o);
      end
    end
    flush_i = 1'b1;
    #1;
    n_checks++;
    if (inst_ready_o !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_ready: got %b expected 0", inst_ready_o);
    end
    step();
    n_checks++;
    if ({id_valid_o, wreg_o} !== 2'b00) begin
      n_errors++;
      $display("FAIL flush_stalled: got %b expected 00", {id_valid_o, wreg_o});
    end
    flush_i = 1'b0;
    #1;
    n_checks++;
    if (inst_ready_o !== 1'b1) begin
      n_errors++;
      $display("FAIL after_flush_ready: got %b expected 1", inst_ready_o);
    end
    step();
    n_checks++;
    if ({ctl, reg1_o, reg2_o} !== {3'b110, 3'b001, 8'h24, 5'd10, 64'h5555, 64'hF0}) begin
      n_errors++;
      $display("FAIL after_flush_issue: ctl=%h reg1=%h reg2=%h expected andi", ctl, reg1_o, reg2_o);
    end
    ex_ready_i = 1'b1; flush_i = 1'b1;
    step();
    n_checks++;
    if ({id_valid_o, wreg_o} !== 2'b00) begin
      n_errors++;
      $display("FAIL flush_over_accept: got %b expected 00", {id_valid_o, wreg_o});
    end
    idle();
  endtask

  task automatic test_error();
    issue(32'h500, {6'h3F, 26'h0}, 64'h0, 64'h0);
    step();
    n_checks++;
    if (ctl[18:13] !== {3'b101, 3'b000}) begin
      n_errors++;
      $display("FAIL bad_opcode: got %b expected 101000", ctl[18:13]);
    end
    issue(32'h504, rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 64'h1, 64'h2);
    step();
    n_checks++;
    if (ctl[18:13] !== {3'b101, 3'b000}) begin
      n_errors++;
      $display("FAIL bad_funct: got %b expected 101000", ctl[18:13]);
    end
    issue(32'h508, itype(6'h0D, 5'd1, 5'd2, 16'h1), 64'h2, 64'h0);
    step();
    n_checks++;
    if ({inst_err_o, wreg_o, reg2_o} !== {2'b01, 64'h1}) begin
      n_errors++;
      $display("FAIL err_cleared: err=%b wreg=%b reg2=%h expected 0 1 1", inst_err_o, wreg_o, reg2_o);
    end
  endtask

  task automatic test_reset_mid();
    issue(32'h600, itype(6'h0D, 5'd1, 5'd2, 16'h7), 64'h3, 64'h0);
    step();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({ctl, reg1_o, reg2_o, pc_o, stall_cnt_o, inst_ready_o, reg1_read_o, reg2_read_o} !== '0) begin
      n_errors++;
      $display("FAIL reset_mid: ctl=%h reg1=%h reg2=%h pc=%h stall=%h ready=%b rd=%b%b expected all zero",
               ctl, reg1_o, reg2_o, pc_o, stall_cnt_o, inst_ready_o, reg1_read_o, reg2_read_o);
    end
    idle();
    rst = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_ori();
    test_immediates();
    test_back_to_back();
    test_load_use();
    test_forward();
    test_backpressure();
    test_error();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
